// File: rtl/vector_lane_sequencer.sv
// -----------------------------------------------------------------------------
// vector_lane_sequencer
//
// Steps the shared scalar ALU/memory datapath across LANES vector elements for
// instructions the control unit flags as vectorial. The pipeline front end is
// held stalled while the sequence runs. Scalar instructions pass through with
// no added latency.
//
// Optional feature (compile-time macro VSEQ_LANE_MASK_EN):
//   Adds input lane_mask[LANES-1:0], latched on accept. Masked lanes produce
//   no register/memory writes, and in MEM they advance without mem_ready.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   asynchronous, active-high reset
//   issue_valid  in   decoded instruction present in decode this cycle
//   vectorial    in   control-unit vectorial flag
//   RegWrite     in   control-unit register-write flag
//   MemWrite     in   control-unit memory-write flag
//   ResultSrc    in   control-unit result select (1 = load result)
//   mem_ready    in   data memory finished the current element access
//   lane_mask    in   per-lane enable (only with VSEQ_LANE_MASK_EN)
//   issue_ready  out  sequencer can accept a new vectorial instruction
//   stall        out  freeze fetch/decode pipeline registers
//   busy         out  vector sequence in progress
//   lane_idx     out  current element index
//   lane_we      out  write enable for vector register element lane_idx
//   lane_mem_we  out  memory write strobe for element lane_idx
//   done         out  one-cycle pulse on the final step
// -----------------------------------------------------------------------------
module vector_lane_sequencer #(
  parameter  int LANES  = 4,
  localparam int LANE_W = $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              vectorial,
  input  logic              RegWrite,
  input  logic              MemWrite,
  input  logic              ResultSrc,
  input  logic              mem_ready,
`ifdef VSEQ_LANE_MASK_EN
  input  logic [LANES-1:0]  lane_mask,
`endif
  output logic              issue_ready,
  output logic              stall,
  output logic              busy,
  output logic [LANE_W-1:0] lane_idx,
  output logic              lane_we,
  output logic              lane_mem_we,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ALU  = 2'd1,
    MEM  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  state_t            r_state;
  state_t            w_next_state;
  logic [LANE_W-1:0] r_lane_idx;
  logic              r_reg_write;
  logic              r_mem_write;
  logic              r_result_src;
  logic              w_accept;
  logic              w_advance;
  logic              w_last;
  logic              w_lane_active;
  logic              w_lane_we;
  logic              w_lane_mem_we;

  assign w_accept = (r_state == IDLE) && issue_valid && vectorial;
  assign w_last   = (r_lane_idx == LAST_LANE);

`ifdef VSEQ_LANE_MASK_EN
  logic [LANES-1:0] r_lane_mask;
  assign w_lane_active = r_lane_mask[r_lane_idx];
`else
  assign w_lane_active = 1'b1;
`endif

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    w_next_state  = r_state;
    w_lane_we     = 1'b0;
    w_lane_mem_we = 1'b0;
    w_advance     = 1'b0;
    unique case (r_state)
      IDLE: begin
        // Route on the incoming flags: they are what gets latched this edge.
        if (w_accept) w_next_state = (MemWrite || ResultSrc) ? MEM : ALU;
      end
      ALU: begin
        w_lane_we = r_reg_write && w_lane_active;
        w_advance = 1'b1;
        if (w_last) w_next_state = DONE;
      end
      MEM: begin
        w_lane_mem_we = r_mem_write && w_lane_active;
        w_lane_we     = r_reg_write && r_result_src && mem_ready && w_lane_active;
        // A masked lane has no access outstanding, so it never waits.
        w_advance     = mem_ready || !w_lane_active;
        if (w_advance && w_last) w_next_state = DONE;
      end
      DONE: w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  // NOTE: state and lane index reset asynchronously; the latched controls are
  // only read after an accept reloads them, but are cleared for determinism.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_lane_idx   <= '0;
      r_reg_write  <= 1'b0;
      r_mem_write  <= 1'b0;
      r_result_src <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_reg_write  <= RegWrite;
        r_mem_write  <= MemWrite;
        r_result_src <= ResultSrc;
        r_lane_idx   <= '0;
      end else if (w_advance) begin
        r_lane_idx <= w_last ? '0 : r_lane_idx + LANE_W'(1);
      end
    end
  end

`ifdef VSEQ_LANE_MASK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)           r_lane_mask <= '0;
    else if (w_accept) r_lane_mask <= lane_mask;
  end
`endif

  // Outputs decode directly from the async-reset state, so a reset drops
  // every write enable in the same cycle it is asserted.
  assign busy        = (r_state == ALU) || (r_state == MEM);
  assign stall       = busy || w_accept;
  assign issue_ready = (r_state == IDLE);
  assign done        = (r_state == DONE);
  assign lane_idx    = r_lane_idx;
  assign lane_we     = w_lane_we;
  assign lane_mem_we = w_lane_mem_we;

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vector_lane_sequencer
//
// Self-checking bench for vector_lane_sequencer (LANES=4). Each table row is
// one clock cycle: inputs are driven on the falling edge and the outputs are
// compared 1 time unit later, before the next rising edge. Multi-cycle corner
// cases (slow-memory store, lane masks) are written out as explicit loops.
// -----------------------------------------------------------------------------
module tb_vector_lane_sequencer;

  localparam int LANES = 4;

  logic       clk;
  logic       rst;
  logic       issue_valid, vectorial, RegWrite, MemWrite, ResultSrc, mem_ready;
  logic       issue_ready, stall, busy, lane_we, lane_mem_we, done;
  logic [1:0] lane_idx;
`ifdef VSEQ_LANE_MASK_EN
  logic [LANES-1:0] lane_mask;
`endif

  int total = 0;
  int bad   = 0;

  vector_lane_sequencer #(.LANES(LANES)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .vectorial   (vectorial),
    .RegWrite    (RegWrite),
    .MemWrite    (MemWrite),
    .ResultSrc   (ResultSrc),
    .mem_ready   (mem_ready),
`ifdef VSEQ_LANE_MASK_EN
    .lane_mask   (lane_mask),
`endif
    .issue_ready (issue_ready),
    .stall       (stall),
    .busy        (busy),
    .lane_idx    (lane_idx),
    .lane_we     (lane_we),
    .lane_mem_we (lane_mem_we),
    .done        (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in  = {rst, issue_valid, vectorial, RegWrite, MemWrite, ResultSrc, mem_ready}
  // exp = {issue_ready, stall, busy, lane_idx[1:0], lane_we, lane_mem_we, done}
  typedef struct {
    string      name;
    logic [6:0] in;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input string name, input logic [6:0] in,
                     input logic [2:0] rsb, input logic [1:0] idx,
                     input logic [2:0] wed);
    vec_t v;
    v.name = name;
    v.in   = in;
    v.exp  = {rsb, idx, wed};
    tbl.push_back(v);
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic [6:0] in);
    @(negedge clk);
    {rst, issue_valid, vectorial, RegWrite, MemWrite, ResultSrc, mem_ready} = in;
    #1;
  endtask

  task automatic check_all(input string name, input logic [7:0] exp);
    check({name, ".issue_ready"}, int'(issue_ready), int'(exp[7]));
    check({name, ".stall"},       int'(stall),       int'(exp[6]));
    check({name, ".busy"},        int'(busy),        int'(exp[5]));
    check({name, ".lane_idx"},    int'(lane_idx),    int'(exp[4:3]));
    check({name, ".lane_we"},     int'(lane_we),     int'(exp[2]));
    check({name, ".lane_mem_we"}, int'(lane_mem_we), int'(exp[1]));
    check({name, ".done"},        int'(done),        int'(exp[0]));
  endtask

  initial begin
    {rst, issue_valid, vectorial, RegWrite, MemWrite, ResultSrc, mem_ready} = 7'b1000000;
`ifdef VSEQ_LANE_MASK_EN
    lane_mask = '1;
`endif

    // ---------------- table: reset, scalar, vector add, load, reset in MEM
    add("reset",        7'b1000000, 3'b100, 2'd0, 3'b000);
    add("idle",         7'b0000000, 3'b100, 2'd0, 3'b000);
    add("scalar_add",   7'b0101000, 3'b100, 2'd0, 3'b000);
    add("mem_rdy_idle", 7'b0101001, 3'b100, 2'd0, 3'b000);
    add("vadd_accept",  7'b0111000, 3'b110, 2'd0, 3'b000);
    add("vadd_l0",      7'b0000000, 3'b011, 2'd0, 3'b100);
    add("vadd_l1",      7'b0111110, 3'b011, 2'd1, 3'b100);
    add("vadd_l2",      7'b0000000, 3'b011, 2'd2, 3'b100);
    add("vadd_l3",      7'b0000000, 3'b011, 2'd3, 3'b100);
    add("vadd_done",    7'b0111000, 3'b000, 2'd0, 3'b001);
    add("no_acc_done",  7'b0000000, 3'b100, 2'd0, 3'b000);
    add("vld_accept",   7'b0111011, 3'b110, 2'd0, 3'b000);
    add("vld_l0",       7'b0000001, 3'b011, 2'd0, 3'b100);
    add("vld_l1",       7'b0001001, 3'b011, 2'd1, 3'b100);
    add("vld_l2",       7'b0000001, 3'b011, 2'd2, 3'b100);
    add("vld_l3",       7'b0001001, 3'b011, 2'd3, 3'b100);
    add("vld_done",     7'b0000000, 3'b000, 2'd0, 3'b001);
    add("vld_idle",     7'b0000000, 3'b100, 2'd0, 3'b000);
    add("vst_accept",   7'b0110100, 3'b110, 2'd0, 3'b000);
    add("vst_l0",       7'b0000001, 3'b011, 2'd0, 3'b010);
    add("vst_l1",       7'b0000001, 3'b011, 2'd1, 3'b010);
    add("vst_l2_wait",  7'b0000000, 3'b011, 2'd2, 3'b010);
    add("rst_in_mem",   7'b1000000, 3'b100, 2'd0, 3'b000);
    add("rst_release",  7'b0000000, 3'b100, 2'd0, 3'b000);

    foreach (tbl[i]) begin
      drive(tbl[i].in);
      check_all(tbl[i].name, tbl[i].exp);
    end

    // ---------------- vector store, mem_ready only every 3rd cycle
    begin
      int exp_lane;
      logic mr;
      exp_lane = 0;
      drive(7'b0110100);
      check_all("slow_st_accept", 8'b110_00_000);
      for (int c = 1; c <= 12; c++) begin
        mr = (c % 3 == 0);
        drive({6'b000000, mr});
        check_all($sformatf("slow_st_c%0d", c), {3'b011, 2'(exp_lane), 3'b010});
        if (mr) exp_lane++;
      end
      drive(7'b0000000);
      check_all("slow_st_done", 8'b000_00_001);
      drive(7'b0000000);
      check_all("slow_st_idle", 8'b100_00_000);
    end

`ifdef VSEQ_LANE_MASK_EN
    // ---------------- masked vector add: only lanes 1 and 3 write
    lane_mask = 4'b1010;
    drive(7'b0111000);
    check_all("mask_add_accept", 8'b110_00_000);
    lane_mask = 4'b1111;  // changes after accept must be ignored
    for (int l = 0; l < LANES; l++) begin
      drive(7'b0000000);
      check_all($sformatf("mask_add_l%0d", l), {3'b011, 2'(l), (l % 2 == 1), 2'b00});
    end
    drive(7'b0000000);
    check_all("mask_add_done", 8'b000_00_001);

    // ---------------- all-masked store walks without mem_ready
    lane_mask = 4'b0000;
    drive(7'b0110100);
    check_all("mask_st_accept", 8'b110_00_000);
    for (int l = 0; l < LANES; l++) begin
      drive(7'b0000000);
      check_all($sformatf("mask_st_l%0d", l), {3'b011, 2'(l), 3'b000});
    end
    drive(7'b0000000);
    check_all("mask_st_done", 8'b000_00_001);
    lane_mask = '1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vector_lane_sequencer.md
Name: vector_lane_sequencer

Overview:
- Multi-cycle sequencer for vectorial instructions flagged by the control unit (vectorial=1).
- Steps the shared scalar ALU/memory datapath across LANES vector elements, one element per step.
- Holds the pipeline stalled until the vector instruction completes.
- Scalar instructions pass through untouched, with zero added latency.

Parameters:
- LANES, 4, number of vector elements per vectorial instruction (power of two, ≥2).
- LANE_W, $clog2(LANES), width of the lane index (derived; not overridden).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue_valid  input  1  decoded instruction present in decode stage this cycle.
- vectorial  input  1  control-unit vectorial flag for that instruction.
- RegWrite  input  1  control-unit register-write flag.
- MemWrite  input  1  control-unit memory-write flag.
- ResultSrc  input  1  control-unit result select (1 = load result).
- mem_ready  input  1  data memory completed the current element access.
- issue_ready  output  1  sequencer can accept a new vectorial instruction.
- stall  output  1  freeze fetch/decode pipeline registers.
- busy  output  1  vector sequence in progress.
- lane_idx  output  LANE_W  element index driving the vector register/address offset mux.
- lane_we  output  1  write enable for vector register element lane_idx.
- lane_mem_we  output  1  memory write strobe for element lane_idx.
- done  output  1  one-cycle pulse on the final step of a vector instruction.

Behaviour:
- States: IDLE, ALU, MEM, DONE. Reset (async, any state) forces IDLE.
- Reset values: lane_idx=0, lane_we=0, lane_mem_we=0, busy=0, done=0, stall=0, issue_ready=1.
- Latched controls: RegWrite/MemWrite/ResultSrc are captured into internal regs on accept.
- Definitions:
  - accept = state==IDLE & issue_valid & vectorial.
  - memop = latched MemWrite | latched ResultSrc.
- IDLE:
  - issue_ready=1.
  - On accept: latch controls; lane_idx←0; next = MEM if memop, else ALU.
  - Scalar instructions (vectorial=0) are ignored; no output changes.
- ALU:
  - lane_we = latched RegWrite (combinational).
  - lane_idx increments every cycle.
  - When lane_idx==LANES-1: next DONE, lane_idx←0.
  - Total ALU-state length is exactly LANES cycles.
- MEM:
  - lane_mem_we = latched MemWrite, held while waiting.
  - lane_we = latched RegWrite & latched ResultSrc & mem_ready.
  - lane_idx advances only on mem_ready; it holds indefinitely otherwise (no timeout).
  - mem_ready on lane LANES-1: next DONE, lane_idx←0.
- DONE: done=1 for one cycle; next IDLE. A new accept is not possible in DONE; the earliest re-accept is the following cycle.
- busy = state ∈ {ALU, MEM}.
- stall = busy | accept (combinational on accept so the instruction holds in decode); stall=0 in DONE so the instruction retires.
- issue_ready = state==IDLE.
- Wrap: lane_idx never exceeds LANES-1; it returns to 0 on leaving ALU/MEM.
- mem_ready while not in MEM: ignored.
- Control inputs changing mid-sequence: ignored (latched copies are used).
- Reset mid-sequence: immediate IDLE; all write enables drop asynchronously; partial element writes already committed are not undone.
- Latency: a vector ALU instruction takes LANES+1 cycles from accept to done (for LANES=4: accept at cycle 0, done at cycle 5).

Optional Feature:
- VSEQ_LANE_MASK_EN:
  - When defined, adds input lane_mask [LANES-1:0], latched on accept.
  - Lanes with mask bit 0 emit lane_we=0 and lane_mem_we=0.
  - In MEM, masked lanes advance in one cycle without waiting for mem_ready.
  - All-zero mask still walks every lane and pulses done.
- When undefined: no lane_mask port; all lanes active.

Test Plan:
- Reset during MEM at lane_idx=2 -> same cycle: lane_mem_we=0, stall=0, busy=0; after release, issue_ready=1, lane_idx=0.
- Scalar add (issue_valid=1, vectorial=0, RegWrite=1) -> stall=0, busy=0, lane_we=0, state stays IDLE.
- Vector add, LANES=4, RegWrite=1, accept at cycle 0:
  - stall=1 at cycles 0-4.
  - lane_we=1 with lane_idx 0,1,2,3 at cycles 1-4.
  - done=1 and stall=0 at cycle 5.
- Vector store, MemWrite=1, mem_ready high only every 3rd cycle:
  - lane_mem_we held high throughout.
  - lane_idx advances only on mem_ready.
  - done one cycle after the 4th mem_ready; lane_we never asserted.
- Vector load, RegWrite=1, ResultSrc=1, mem_ready constant 1:
  - lane_we=1 for lanes 0-3 on consecutive cycles; done at cycle 5.
  - Toggling the RegWrite input mid-sequence has no effect.
- (VSEQ_LANE_MASK_EN) Vector add with mask 4'b1010 -> lane_we=1 only at lane_idx 1 and 3; done at cycle 5. Store with mask 4'b0000 -> lane_mem_we never asserted; done at cycle 5.
